// File: rtl/serial_adder_pkg.sv
// Shared types for serial_adder: FSM state encoding and step-counter sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } saState_t;

    // A counter for one step still needs a bit, so never return zero.
    function automatic int stepCntWidth(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_fulladder.sv
// 1-bit full adder cell, the ripple element of the serial adder chain.
// Latency: combinational.
// Backpressure: none.
module fullAdder (
    input  logic faOp1,
    input  logic faOp2,
    input  logic faCi,
    output logic faRes,
    output logic faCo
);

    assign faRes = faOp1 ^ faOp2 ^ faCi;
    assign faCo  = (faOp1 & faOp2) | (faCi & (faOp1 ^ faOp2));

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle add/subtract, DIGIT bits per clock, LSB digit first, with carry and overflow flags.
// Latency: start accepted at edge k -> saDone high in cycle k+WIDTH/DIGIT+1.
// Backpressure: saStart is ignored while saBusy; no queueing.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             saStart,
    input  logic             saSub,
    input  logic [WIDTH-1:0] saOp1,
    input  logic [WIDTH-1:0] saOp2,
    input  logic             saCi,
    output logic             saBusy,
    output logic             saDone,
    output logic [WIDTH-1:0] saRes,
    output logic             saCo,
    output logic             saOvf
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = stepCntWidth(STEPS);
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

    if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : gParamCheck
        $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    saState_t         state, nextState;
    logic [WIDTH-1:0] regA, regB, resSr, resNext;
    logic             carry;
    logic [CW-1:0]    stepCnt;
    logic [DIGIT-1:0] sumDig;
    logic [DIGIT:0]   chain;
    logic             accept, lastStep;

    assign chain[0] = carry;

    for (genvar i = 0; i < DIGIT; i++) begin : gCell
        fullAdder uCell (
            .faOp1 (regA[i]),
            .faOp2 (regB[i]),
            .faCi  (chain[i]),
            .faRes (sumDig[i]),
            .faCo  (chain[i+1])
        );
    end

    // The newest digit enters from the MSB side, so after STEPS shifts the word is aligned.
    if (STEPS == 1) begin : gResOne
        assign resNext = sumDig;
    end else begin : gResShift
        assign resNext = {sumDig, resSr[WIDTH-1:DIGIT]};
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        accept    = 1'b0;
        lastStep  = (state == RUN) && (stepCnt == LAST_STEP);
        case (state)
            IDLE: if (saStart) begin
                accept    = 1'b1;
                nextState = RUN;
            end
            RUN:  if (stepCnt == LAST_STEP) nextState = DONE;
            DONE: begin
                accept    = saStart;
                nextState = saStart ? RUN : IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regA    <= '0;
            regB    <= '0;
            resSr   <= '0;
            carry   <= 1'b0;
            stepCnt <= '0;
            saRes   <= '0;
            saCo    <= 1'b0;
            saOvf   <= 1'b0;
        end else if (accept) begin
            // Subtraction is a + ~b + ~borrow, so the chain itself only ever adds.
            regA    <= saOp1;
            regB    <= saSub ? ~saOp2 : saOp2;
            carry   <= saSub ? ~saCi : saCi;
            stepCnt <= '0;
        end else if (state == RUN) begin
            regA  <= regA >> DIGIT;
            regB  <= regB >> DIGIT;
            resSr <= resNext;
            carry <= chain[DIGIT];
            if (!lastStep) stepCnt <= stepCnt + 1'b1;
            if (lastStep) begin
                saRes <= resNext;
                saCo  <= chain[DIGIT];
                saOvf <= chain[DIGIT] ^ chain[DIGIT-1];
            end
        end
    end

    assign saBusy = (state == RUN);
    assign saDone = (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at DIGIT=1 and DIGIT=4, directed cases plus random ops vs arithmetic model.
module tb_serial_adder;

    logic       clk;
    logic       rst;
    logic [1:0] start, sub, ci;
    logic [7:0] op1 [2];
    logic [7:0] op2 [2];
    logic [1:0] busy, done, co, ovf;
    logic [7:0] res [2];

    int checks = 0;
    int errors = 0;

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk(clk), .rst(rst), .saStart(start[0]), .saSub(sub[0]),
        .saOp1(op1[0]), .saOp2(op2[0]), .saCi(ci[0]),
        .saBusy(busy[0]), .saDone(done[0]), .saRes(res[0]), .saCo(co[0]), .saOvf(ovf[0])
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst(rst), .saStart(start[1]), .saSub(sub[1]),
        .saOp1(op1[1]), .saOp2(op2[1]), .saCi(ci[1]),
        .saBusy(busy[1]), .saDone(done[1]), .saRes(res[1]), .saCo(co[1]), .saOvf(ovf[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {ovf, co, res[7:0]} computed from plain integer arithmetic.
    function automatic logic [9:0] refModel(input logic [7:0] a, input logic [7:0] b,
                                            input logic s, input logic c);
        int ua, ub, sa, sb, u, sv;
        logic [7:0] r;
        logic rc, rv;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        if (!s) begin
            u  = ua + ub + int'(c);
            sv = sa + sb + int'(c);
            rc = (u > 255);
        end else begin
            u  = ua - ub - int'(c);
            sv = sa - sb - int'(c);
            rc = (u >= 0);
        end
        r  = u[7:0];
        rv = (sv > 127) || (sv < -128);
        return {rv, rc, r};
    endfunction

    task automatic waitDone(input int sel, output int cyc, output int busyCnt);
        cyc = 0;
        busyCnt = 0;
        while (done[sel] !== 1'b1 && cyc < 100) begin
            if (busy[sel] === 1'b1) busyCnt++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic checkResult(input string tag, input int sel, input logic [9:0] exp);
        check({tag, ".done"}, done[sel], 1'b1);
        check({tag, ".res"},  res[sel],  exp[7:0]);
        check({tag, ".co"},   co[sel],   exp[8]);
        check({tag, ".ovf"},  ovf[sel],  exp[9]);
    endtask

    // One op from idle: accept, count busy cycles, check result and the single-cycle done pulse.
    task automatic runOp(input string tag, input int sel, input logic [7:0] a, input logic [7:0] b,
                         input logic s, input logic c, input int steps);
        int cyc, bc;
        logic [9:0] exp;
        exp = refModel(a, b, s, c);
        @(negedge clk);
        op1[sel] = a; op2[sel] = b; sub[sel] = s; ci[sel] = c; start[sel] = 1'b1;
        @(negedge clk);
        start[sel] = 1'b0;
        op1[sel] = 8'($urandom); op2[sel] = 8'($urandom);
        sub[sel] = 1'($urandom); ci[sel] = 1'($urandom);
        waitDone(sel, cyc, bc);
        check({tag, ".latency"}, cyc, steps);
        check({tag, ".busycnt"}, bc, steps);
        checkResult(tag, sel, exp);
        @(negedge clk);
        check({tag, ".pulse"}, done[sel], 1'b0);
        check({tag, ".hold"}, res[sel], exp[7:0]);
    endtask

    initial begin
        int cyc, bc, seen;
        logic [9:0] e1, e2;
        logic [7:0] ra, rb;

        rst = 1'b1; start = '0; sub = '0; ci = '0;
        op1[0] = '0; op2[0] = '0; op1[1] = '0; op2[1] = '0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("rst.busy", busy[s], 1'b0);
            check("rst.done", done[s], 1'b0);
            check("rst.res",  res[s],  8'h00);
            check("rst.co",   co[s],   1'b0);
            check("rst.ovf",  ovf[s],  1'b0);
        end
        rst = 1'b0;

        runOp("add",     0, 8'h3C, 8'h0F, 1'b0, 1'b0, 8);
        check("add.fixed", res[0], 8'h4B);
        runOp("carry",   0, 8'hFF, 8'h01, 1'b0, 1'b0, 8);
        check("carry.fixed", co[0], 1'b1);
        runOp("ovf",     0, 8'h7F, 8'h01, 1'b0, 1'b0, 8);
        check("ovf.fixed", {ovf[0], res[0]}, {1'b1, 8'h80});
        runOp("sub",     0, 8'h05, 8'h07, 1'b1, 1'b0, 8);
        check("sub.fixed", {co[0], res[0]}, {1'b0, 8'hFE});

        // Start pulsed at busy cycle 3 must be dropped.
        @(negedge clk);
        op1[0] = 8'h10; op2[0] = 8'h20; sub[0] = 1'b0; ci[0] = 1'b0; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (2) @(negedge clk);
        op1[0] = 8'hFF; op2[0] = 8'hFF; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        waitDone(0, cyc, bc);
        check("ignore.latency", cyc, 5);
        checkResult("ignore", 0, 10'h030);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done[0] === 1'b1 || busy[0] === 1'b1) seen++;
        end
        check("ignore.nosecond", seen, 0);

        // Reset during busy cycle 4 aborts with no completion.
        @(negedge clk);
        op1[0] = 8'h11; op2[0] = 8'h22; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("abort.busy4", busy[0], 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort.busy", busy[0], 1'b0);
        check("abort.res",  res[0],  8'h00);
        check("abort.done", done[0], 1'b0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done[0] === 1'b1) seen++;
        end
        check("abort.nodone", seen, 0);
        runOp("fresh", 0, 8'h22, 8'h33, 1'b0, 1'b1, 8);

        // DIGIT=4, then a start held in the DONE cycle chains straight into RUN.
        ra = 8'($urandom); rb = 8'($urandom);
        e2 = refModel(ra, rb, 1'b1, 1'b1);
        @(negedge clk);
        op1[1] = 8'hA5; op2[1] = 8'h5A; sub[1] = 1'b0; ci[1] = 1'b1; start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        waitDone(1, cyc, bc);
        check("d4.latency", cyc, 2);
        check("d4.busycnt", bc, 2);
        checkResult("d4", 1, 10'h100);
        op1[1] = ra; op2[1] = rb; sub[1] = 1'b1; ci[1] = 1'b1; start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        check("b2b.nogap", busy[1], 1'b1);
        check("b2b.hold",  {co[1], res[1]}, {1'b1, 8'h00});
        waitDone(1, cyc, bc);
        check("b2b.latency", cyc, 2);
        checkResult("b2b", 1, e2);
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            for (int s = 0; s < 2; s++) begin
                e1 = 10'($urandom);
                runOp("rand", s, e1[7:0], 8'($urandom), e1[8], e1[9], (s == 0) ? 8 : 2);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
